// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer; ready is registered toward the producer.
// Optional statistics counters are compiled in with `define PIPE_STATS_EN.
module pipe_stage_skid_reg #(
  parameter int unsigned CTRL_W = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEST_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [DEST_W-1:0] out_dest
`ifdef PIPE_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  // Bit 0 is the main-entry valid, bit 1 the skid-entry valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t state;

  logic              main_valid;
  logic              skid_valid;
  logic              accept;
  logic              pop;

  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data0;
  logic [DATA_W-1:0] main_data1;
  logic [DEST_W-1:0] main_dest;

  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data0;
  logic [DATA_W-1:0] skid_data1;
  logic [DEST_W-1:0] skid_dest;

  always_comb begin
    main_valid = state[0];
    skid_valid = state[1];
    in_ready   = ~skid_valid & ~freeze & ~flush;
    out_valid  = main_valid & ~freeze & ~flush;
    accept     = in_valid & in_ready;
    pop        = out_valid & out_ready;
    out_ctrl   = main_ctrl & {CTRL_W{out_valid}};
    out_data0  = main_data0;
    out_data1  = main_data1;
    out_dest   = main_dest;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      main_ctrl  <= '0;
      main_data0 <= '0;
      main_data1 <= '0;
      main_dest  <= '0;
      skid_ctrl  <= '0;
      skid_data0 <= '0;
      skid_data1 <= '0;
      skid_dest  <= '0;
    end else if (flush) begin
      // Data fields are kept; only the valid bits are dropped.
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state      <= ONE;
            main_ctrl  <= in_ctrl;
            main_data0 <= in_data0;
            main_data1 <= in_data1;
            main_dest  <= in_dest;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_ctrl  <= in_ctrl;
            main_data0 <= in_data0;
            main_data1 <= in_data1;
            main_dest  <= in_dest;
          end else if (accept) begin
            state      <= TWO;
            skid_ctrl  <= in_ctrl;
            skid_data0 <= in_data0;
            skid_data1 <= in_data1;
            skid_dest  <= in_dest;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state      <= ONE;
            main_ctrl  <= skid_ctrl;
            main_data0 <= skid_data0;
            main_data1 <= skid_data1;
            main_dest  <= skid_dest;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (stats_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (main_valid && (!out_ready || freeze) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      // A held skid entry implies a held main entry, so main_valid covers both.
      if (flush && main_valid && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Randomized self-checking bench for pipe_stage_skid_reg against a queue-based model of the stage.
module tb_pipe_stage_skid_reg;
  localparam int unsigned CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_ctrl = '0;
  logic [31:0] in_data0 = '0;
  logic [31:0] in_data1 = '0;
  logic [3:0]  in_dest = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  out_ctrl;
  logic [31:0] out_data0;
  logic [31:0] out_data1;
  logic [3:0]  out_dest;
`ifdef PIPE_STATS_EN
  logic             stats_clr = 1'b0;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  int unsigned      m_stall = 0;
  int unsigned      m_flush = 0;
`endif

  pipe_stage_skid_reg #(.CTRL_W(3), .DATA_W(32), .DEST_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_data0(in_data0), .in_data1(in_data1), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data0(out_data0), .out_data1(out_data1), .out_dest(out_dest)
`ifdef PIPE_STATS_EN
    , .stats_clr(stats_clr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [3:0]  dest;
  } ent_t;

  // Model: queue of held entries in arrival order; 'shown' is what the data outputs display.
  ent_t q[$];
  ent_t shown = '0;
  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  function automatic logic [72:0] exp_outs();
    logic v, r;
    v = (q.size() > 0) && !freeze && !flush;
    r = (q.size() < 2) && !freeze && !flush;
    return {v, r, (v ? shown.ctrl : 3'b000), shown.d0, shown.d1, shown.dest};
  endfunction

  function automatic logic [72:0] dut_outs();
    return {out_valid, in_ready, out_ctrl, out_data0, out_data1, out_dest};
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    e.ctrl = 3'($urandom);
    e.d0   = $urandom;
    e.d1   = $urandom;
    e.dest = 4'($urandom);
    return e;
  endfunction

  task automatic drive(input logic v, input ent_t e);
    in_valid = v;
    in_ctrl  = e.ctrl;
    in_data0 = e.d0;
    in_data1 = e.d1;
    in_dest  = e.dest;
  endtask

  task automatic model_reset();
    q.delete();
    shown = '0;
`ifdef PIPE_STATS_EN
    m_stall = 0;
    m_flush = 0;
`endif
  endtask

  // Advance one clock and apply the handshake rules to the model; inputs are stable across the edge.
  task automatic step();
    logic v, r, acc, pp;
    ent_t cur;
    @(posedge clk);
    v   = (q.size() > 0) && !freeze && !flush;
    r   = (q.size() < 2) && !freeze && !flush;
    acc = in_valid && r;
    pp  = v && out_ready;
    cur = {in_ctrl, in_data0, in_data1, in_dest};
    if (!rst) begin
      model_reset();
    end else begin
`ifdef PIPE_STATS_EN
      if (stats_clr) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        if (q.size() > 0 && (!out_ready || freeze) && m_stall < 15) m_stall++;
        if (flush && q.size() > 0 && m_flush < 15) m_flush++;
      end
`endif
      if (flush) q.delete();
      else begin
        if (pp) void'(q.pop_front());
        if (acc) q.push_back(cur);
      end
      if (q.size() > 0) shown = q[0];
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    model_reset();
    #2;
    total_cnt++;
    if (dut_outs() !== exp_outs()) $display("FAIL reset_hold: got %h want %h", dut_outs(), exp_outs());
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL reset_release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_latency();
    ent_t e;
    e = {3'b101, 32'hA5A5_0001, 32'h0000_1234, 4'h7};
    out_ready = 1'b1;
    drive(1'b1, e);
    step();
    drive(1'b0, '0);
    #1;
    total_cnt++;
    if ({out_valid, out_data0, out_ctrl, out_dest} !== {1'b1, 32'hA5A5_0001, 3'b101, 4'h7})
      $display("FAIL latency: got v=%b d0=%h c=%b t=%h want v=1 d0=a5a50001 c=101 t=7", out_valid, out_data0, out_ctrl, out_dest);
    else pass_cnt++;
    step();
    #1;
    total_cnt++;
    if (dut_outs() !== exp_outs()) $display("FAIL latency_drain: got %h want %h", dut_outs(), exp_outs());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int unsigned sent = 0;
    int unsigned got = 0;
    int unsigned order_err = 0;
    logic saw_not_ready = 1'b0;
    ent_t e;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      out_ready = !(cyc >= 2 && cyc <= 4);
      e = rand_ent();
      e.d0 = 32'hB000_0000 + sent;
      drive(sent < 8, e);
      #1;
      total_cnt++;
      if (dut_outs() !== exp_outs()) $display("FAIL b2b cyc%0d: got %h want %h", cyc, dut_outs(), exp_outs());
      else pass_cnt++;
      if (!in_ready) saw_not_ready = 1'b1;
      if (out_valid && out_ready) begin
        if (out_data0 !== 32'hB000_0000 + got) order_err++;
        got++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    drive(1'b0, '0);
    total_cnt++;
    if (got !== 8 || order_err !== 0) $display("FAIL b2b_order: got %0d entries %0d misordered want 8 entries 0 misordered", got, order_err);
    else pass_cnt++;
    total_cnt++;
    if (saw_not_ready !== 1'b1) $display("FAIL b2b_backpressure: in_ready drop seen=%b want 1", saw_not_ready);
    else pass_cnt++;
  endtask

  task automatic fill_two(input logic [31:0] base);
    ent_t e;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e = rand_ent();
      e.d0 = base + i;
      e.ctrl = 3'b111;
      drive(1'b1, e);
      step();
    end
  endtask

  task automatic test_freeze();
    fill_two(32'hC000_0000);
    freeze = 1'b1;
    drive(1'b1, rand_ent());
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (dut_outs() !== exp_outs() || out_ctrl !== 3'b000 || in_ready !== 1'b0)
        $display("FAIL freeze cyc%0d: got %h want %h", i, dut_outs(), exp_outs());
      else pass_cnt++;
      step();
    end
    freeze = 1'b0;
    drive(1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (dut_outs() !== exp_outs()) $display("FAIL freeze_release cyc%0d: got %h want %h", i, dut_outs(), exp_outs());
      else pass_cnt++;
      if (i < 2) begin
        total_cnt++;
        if (out_valid !== 1'b1 || out_data0 !== 32'hC000_0000 + i)
          $display("FAIL freeze_order %0d: got v=%b d0=%h want v=1 d0=%h", i, out_valid, out_data0, 32'hC000_0000 + i);
        else pass_cnt++;
      end
      step();
    end
  endtask

  task automatic test_flush();
`ifdef PIPE_STATS_EN
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
`endif
    fill_two(32'hD000_0000);
    flush = 1'b1;
    drive(1'b1, rand_ent());
    #1;
    total_cnt++;
    if (dut_outs() !== exp_outs() || in_ready !== 1'b0) $display("FAIL flush_same: got %h want %h", dut_outs(), exp_outs());
    else pass_cnt++;
    step();
    flush = 1'b0;
    drive(1'b0, '0);
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if ({out_valid, in_ready, out_ctrl} !== {1'b0, 1'b1, 3'b000})
      $display("FAIL flush_after: got v=%b r=%b c=%b want v=0 r=1 c=000", out_valid, in_ready, out_ctrl);
    else pass_cnt++;
`ifdef PIPE_STATS_EN
    total_cnt++;
    if (flush_cnt !== 4'd1) $display("FAIL flush_cnt: got %0d want 1", flush_cnt);
    else pass_cnt++;
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL flush_ghost cyc%0d: got v=%b want 0", i, out_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, rand_ent());
    step();
    drive(1'b0, '0);
    #2 rst = 1'b0;
    model_reset();
    #1;
    total_cnt++;
    if ({out_valid, out_ctrl, out_data0, out_data1, out_dest} !== '0)
      $display("FAIL reset_mid: got v=%b c=%b d0=%h d1=%h t=%h want all 0", out_valid, out_ctrl, out_data0, out_data1, out_dest);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, {3'b011, 32'hE000_0042, 32'h1, 4'h3});
    step();
    drive(1'b0, '0);
    #1;
    total_cnt++;
    if ({out_valid, out_data0, out_ctrl} !== {1'b1, 32'hE000_0042, 3'b011})
      $display("FAIL reset_mid_latency: got v=%b d0=%h c=%b want v=1 d0=e0000042 c=011", out_valid, out_data0, out_ctrl);
    else pass_cnt++;
    step();
  endtask

`ifdef PIPE_STATS_EN
  task automatic test_stats();
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, rand_ent());
    step();
    drive(1'b0, '0);
    for (int i = 0; i < 20; i++) step();
    total_cnt++;
    if (stall_cnt !== 4'hF) $display("FAIL stall_sat: got %h want f", stall_cnt);
    else pass_cnt++;
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    total_cnt++;
    if (stall_cnt !== 4'h0 || flush_cnt !== 4'h0) $display("FAIL stats_clr: got %h/%h want 0/0", stall_cnt, flush_cnt);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    step();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, rand_ent());
      out_ready = ($urandom % 3) != 0;
      freeze    = ($urandom % 10) == 0;
      flush     = ($urandom % 23) == 0;
`ifdef PIPE_STATS_EN
      stats_clr = ($urandom % 61) == 0;
`endif
      #1;
      total_cnt++;
      if (dut_outs() !== exp_outs()) $display("FAIL random cyc%0d: got %h want %h", i, dut_outs(), exp_outs());
      else pass_cnt++;
`ifdef PIPE_STATS_EN
      total_cnt++;
      if (stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush))
        $display("FAIL random_stats cyc%0d: got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, m_stall, m_flush);
      else pass_cnt++;
`endif
      step();
    end
    freeze = 1'b0;
    flush  = 1'b0;
    drive(1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_freeze();
    test_flush();
    test_reset_mid();
`ifdef PIPE_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised successor to the fixed-width EX/MEM stage register.
- Carries a control vector, two data words and a destination tag between adjacent pipeline stages.
- Adds a valid/ready handshake, a 2-entry skid buffer (registered in_ready, no combinational ready path upstream), freeze (stall) and flush (bubble insertion).
- Instantiated between every stage pair (ID/EX, EX/MEM, MEM/WB) with per-instance widths.

Parameters:
- CTRL_W, 3: control-enable bits, e.g. {WB_EN, MEM_R_EN, MEM_W_EN}; forced to 0 on bubbles.
- DATA_W, 32: width of each data word.
- DEST_W, 4: destination register tag width.
- CNT_W, 16: statistics counter width (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- freeze  in  1  hold all state; no accept, no pop
- flush  in  1  synchronous discard of all held entries
- in_valid  in  1  producer has an entry
- in_ready  out  1  block can accept an entry
- in_ctrl  in  CTRL_W  control enables
- in_data0  in  DATA_W  ALU result / primary data
- in_data1  in  DATA_W  store value / secondary data
- in_dest  in  DEST_W  destination tag
- out_valid  out  1  entry presented downstream
- out_ready  in  1  consumer takes the entry
- out_ctrl  out  CTRL_W  control enables, gated by out_valid
- out_data0  out  DATA_W  main-entry data0
- out_data1  out  DATA_W  main-entry data1
- out_dest  out  DEST_W  main-entry tag

Behaviour:
- Storage: a main entry (drives the outputs) and a skid entry. Both hold ctrl, data0, data1 and dest.
- State is encoded by the valid bits: EMPTY (none), ONE (main), TWO (main + skid).
- Reset (rst low, asynchronous): state EMPTY; all entry fields 0; outputs 0. After reset release, in_ready=1.
- Accept: in_valid & in_ready. Pop: out_valid & out_ready.
- in_ready = ~skid_valid & ~freeze & ~flush. skid_valid is a register; freeze and flush are the only combinational terms.
- out_valid = main_valid & ~freeze & ~flush.
- out_ctrl = main_ctrl AND out_valid (per bit). Bubbles never carry enables. out_data0, out_data1 and out_dest show the main contents regardless of out_valid.
- Transitions (freeze=0, flush=0):
  - EMPTY + accept -> ONE; main <= in.
  - ONE + accept + pop -> ONE; main <= in.
  - ONE + accept, no pop -> TWO; skid <= in.
  - ONE + pop, no accept -> EMPTY; main fields retained, valid cleared.
  - TWO + pop -> ONE; main <= skid; skid valid cleared. Accept is impossible in TWO.
  - No accept and no pop: hold.
- Latency: 1 cycle from accept to out_valid when the block is empty and unstalled.
- freeze=1: every register holds. in_ready=0 and out_valid=0, so no transfer occurs.
- flush=1: has priority over freeze, accept and pop. The next edge goes to EMPTY and clears both valid bits. Data fields are retained but masked.
- Simultaneous flush and in_valid: the incoming entry is dropped (in_ready=0). The producer re-issues it.
- Reset asserted mid-transfer: all entries are lost immediately and outputs go to 0 asynchronously.

Optional Feature:
- Macro: PIPE_STATS_EN.
- Defined:
  - Extra ports: stats_clr (in, 1), stall_cnt (out, CNT_W), flush_cnt (out, CNT_W).
  - stall_cnt increments on each cycle where main_valid=1 and (out_ready=0 or freeze=1).
  - flush_cnt increments on each flush cycle in which at least one valid entry is discarded.
  - Both counters saturate at all-ones.
  - stats_clr zeroes both counters synchronously and has priority over increment.
  - rst zeroes both counters.
- Undefined: the ports and logic are absent. Handshake behaviour is identical.

Test Plan:
- Reset release, then in_valid=1, in_data0=32'hA5A5_0001, in_ctrl=3'b101, dest=4'h7, out_ready=1 -> next cycle out_valid=1, out_data0=32'hA5A5_0001, out_ctrl=3'b101, out_dest=4'h7.
- Back-to-back stream of 8 entries with out_ready=0 for cycles 2-4 -> in_ready drops after 2 entries are held, and all 8 entries emerge in order with no loss or duplication.
- freeze=1 for 3 cycles while in state TWO -> in_ready=0, out_valid=0, out_ctrl=3'b000. After release, the entries emerge in original order.
- flush=1 in state TWO while in_valid=1 -> next cycle out_valid=0, in_ready=1, out_ctrl=0. The flushed entries never appear. With PIPE_STATS_EN, flush_cnt=1.
- rst pulsed low mid-stream (state ONE) -> outputs are 0 within the same cycle and state is EMPTY. The first accept after release shows a latency of 1.
- PIPE_STATS_EN with CNT_W=4 and out_ready=0 held for 20 cycles with main valid -> stall_cnt saturates at 4'hF. stats_clr=1 -> next cycle 0.
